// File: rtl/game_pkg.sv
// Shared definitions for the game round controller.
// Holds the controller state encoding, the default game parameters and the
// score ceiling shown on the single-digit score display.
package game_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StGen,
    StArm,
    StWait,
    StLoad,
    StCheck,
    StResult,
    StDone
  } state_e;

  localparam int unsigned NumRoundsDefault    = 5;
  localparam int unsigned ResultCyclesDefault = 50_000_000;

  // Score is a single decimal digit on the display.
  localparam logic [3:0] MaxScore = 4'd9;

endpackage

// File: rtl/hold_counter.sv
// Down-counter that times how long the round-result LEDs stay lit.
//   clk_i   : clock
//   rst_ni  : asynchronous active-low reset, clears the count
//   clr_i   : synchronous clear (session ended)
//   load_i  : load Cycles-1 so that done_o rises after Cycles cycles
//   en_i    : count down while asserted
//   done_o  : count has reached zero
module hold_counter #(
  parameter int unsigned Cycles = 2
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic clr_i,
  input  logic load_i,
  input  logic en_i,
  output logic done_o
);

  localparam int unsigned CntW = (Cycles > 1) ? $clog2(Cycles) : 1;
  localparam logic [CntW-1:0] LoadVal = CntW'(Cycles - 1);

  logic [CntW-1:0] cnt_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else if (clr_i) begin
      cnt_q <= '0;
    end else if (load_i) begin
      cnt_q <= LoadVal;
    end else if (en_i && (cnt_q != '0)) begin
      cnt_q <= cnt_q - 1'b1;
    end
  end

  assign done_o = (cnt_q == '0);

endmodule

// File: rtl/game_round_controller.sv
// Round sequencer for the sum-guessing game.
// Runs NUM_ROUNDS rounds per game: request an operand, reload and run the
// answer timer, load the player's answer, grade it and show the result on the
// LEDs for RESULT_CYCLES cycles. All outputs are registered.
//   clk_i            : clock
//   rst_ni           : asynchronous active-low reset
//   logged_in_i      : user authenticated (level); 0 aborts to idle
//   start_pulse_i    : start / restart request (one cycle)
//   answer_pulse_i   : player submit (one cycle)
//   sum_match_i      : answer correct, valid the cycle after load_p1_o
//   timer_expired_i  : answer timer reached zero (level)
//   rng_gen_o        : request new operand (one cycle)
//   load_p1_o        : load player-1 register (one cycle)
//   timer_reconfig_o : reload answer timer (one cycle)
//   timer_enable_o   : answer timer running
//   score_o          : rounds won, 0..9
//   round_num_o      : current round, 1..NUM_ROUNDS, 0 when idle
//   win_led_o        : round won indicator
//   lose_led_o       : round lost indicator
//   game_over_o      : final round finished
module game_round_controller
  import game_pkg::*;
#(
  parameter int unsigned NUM_ROUNDS    = NumRoundsDefault,
  parameter int unsigned RESULT_CYCLES = ResultCyclesDefault
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       logged_in_i,
  input  logic       start_pulse_i,
  input  logic       answer_pulse_i,
  input  logic       sum_match_i,
  input  logic       timer_expired_i,
  output logic       rng_gen_o,
  output logic       load_p1_o,
  output logic       timer_reconfig_o,
  output logic       timer_enable_o,
  output logic [3:0] score_o,
  output logic [3:0] round_num_o,
  output logic       win_led_o,
  output logic       lose_led_o,
  output logic       game_over_o
);

  localparam logic [3:0] LastRound = 4'(NUM_ROUNDS);

  state_e     state_q;
  logic       rng_gen_q, load_p1_q, timer_reconfig_q, timer_enable_q;
  logic       win_led_q, lose_led_q, game_over_q;
  logic [3:0] score_q, round_num_q;

  logic hold_load, hold_en, hold_done;

  // Load the LED hold time on every entry into StResult.
  assign hold_load = logged_in_i &&
                     (((state_q == StWait) && timer_expired_i) || (state_q == StCheck));
  assign hold_en   = (state_q == StResult);

  hold_counter #(
    .Cycles (RESULT_CYCLES)
  ) u_hold_counter (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .clr_i  (!logged_in_i),
    .load_i (hold_load),
    .en_i   (hold_en),
    .done_o (hold_done)
  );

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q          <= StIdle;
      rng_gen_q        <= 1'b0;
      load_p1_q        <= 1'b0;
      timer_reconfig_q <= 1'b0;
      timer_enable_q   <= 1'b0;
      score_q          <= 4'd0;
      round_num_q      <= 4'd0;
      win_led_q        <= 1'b0;
      lose_led_q       <= 1'b0;
      game_over_q      <= 1'b0;
    end else begin
      // Strobes are single-cycle unless re-asserted below.
      rng_gen_q        <= 1'b0;
      load_p1_q        <= 1'b0;
      timer_reconfig_q <= 1'b0;
      if (!logged_in_i) begin
        state_q        <= StIdle;
        timer_enable_q <= 1'b0;
        score_q        <= 4'd0;
        round_num_q    <= 4'd0;
        win_led_q      <= 1'b0;
        lose_led_q     <= 1'b0;
        game_over_q    <= 1'b0;
      end else begin
        unique case (state_q)
          StIdle, StDone: begin
            if (start_pulse_i) begin
              state_q     <= StGen;
              rng_gen_q   <= 1'b1;
              score_q     <= 4'd0;
              round_num_q <= 4'd1;
              game_over_q <= 1'b0;
            end
          end
          StGen: begin
            state_q          <= StArm;
            timer_reconfig_q <= 1'b1;
          end
          StArm: begin
            state_q        <= StWait;
            timer_enable_q <= 1'b1;
          end
          StWait: begin
            // A timeout in the same cycle as a submit counts as a loss.
            if (timer_expired_i) begin
              state_q        <= StResult;
              timer_enable_q <= 1'b0;
              lose_led_q     <= 1'b1;
            end else if (answer_pulse_i) begin
              state_q        <= StLoad;
              timer_enable_q <= 1'b0;
              load_p1_q      <= 1'b1;
            end
          end
          StLoad: begin
            state_q <= StCheck;
          end
          StCheck: begin
            state_q <= StResult;
            if (sum_match_i) begin
              win_led_q <= 1'b1;
              if (score_q < MaxScore) score_q <= score_q + 4'd1;
            end else begin
              lose_led_q <= 1'b1;
            end
          end
          StResult: begin
            if (hold_done) begin
              win_led_q  <= 1'b0;
              lose_led_q <= 1'b0;
              if (round_num_q == LastRound) begin
                state_q     <= StDone;
                game_over_q <= 1'b1;
              end else begin
                state_q     <= StGen;
                rng_gen_q   <= 1'b1;
                round_num_q <= round_num_q + 4'd1;
              end
            end
          end
          default: begin
            state_q <= StIdle;
          end
        endcase
      end
    end
  end

  assign rng_gen_o        = rng_gen_q;
  assign load_p1_o        = load_p1_q;
  assign timer_reconfig_o = timer_reconfig_q;
  assign timer_enable_o   = timer_enable_q;
  assign score_o          = score_q;
  assign round_num_o      = round_num_q;
  assign win_led_o        = win_led_q;
  assign lose_led_o       = lose_led_q;
  assign game_over_o      = game_over_q;

endmodule

// File: tb/tb_game_round_controller.sv
// Bench for game_round_controller: two instances (5 rounds / 4-cycle hold and
// 9 rounds / 2-cycle hold) driven by directed sequences, compared each cycle
// against a behavioural model, plus hand-computed spot checks.
module tb_game_round_controller;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic li [2], st [2], ans [2], sm [2], te [2];
  logic rng_o [2], load_o [2], reconf_o [2], ten_o [2], win_o [2], lose_o [2], over_o [2];
  logic [3:0] score_o [2], round_o [2];

  int n_checks = 0;
  int n_errors = 0;

  game_round_controller #(
    .NUM_ROUNDS    (5),
    .RESULT_CYCLES (4)
  ) u_dut5 (
    .clk_i            (clk),
    .rst_ni           (rst_n),
    .logged_in_i      (li[0]),
    .start_pulse_i    (st[0]),
    .answer_pulse_i   (ans[0]),
    .sum_match_i      (sm[0]),
    .timer_expired_i  (te[0]),
    .rng_gen_o        (rng_o[0]),
    .load_p1_o        (load_o[0]),
    .timer_reconfig_o (reconf_o[0]),
    .timer_enable_o   (ten_o[0]),
    .score_o          (score_o[0]),
    .round_num_o      (round_o[0]),
    .win_led_o        (win_o[0]),
    .lose_led_o       (lose_o[0]),
    .game_over_o      (over_o[0])
  );

  game_round_controller #(
    .NUM_ROUNDS    (9),
    .RESULT_CYCLES (2)
  ) u_dut9 (
    .clk_i            (clk),
    .rst_ni           (rst_n),
    .logged_in_i      (li[1]),
    .start_pulse_i    (st[1]),
    .answer_pulse_i   (ans[1]),
    .sum_match_i      (sm[1]),
    .timer_expired_i  (te[1]),
    .rng_gen_o        (rng_o[1]),
    .load_p1_o        (load_o[1]),
    .timer_reconfig_o (reconf_o[1]),
    .timer_enable_o   (ten_o[1]),
    .score_o          (score_o[1]),
    .round_num_o      (round_o[1]),
    .win_led_o        (win_o[1]),
    .lose_led_o       (lose_o[1]),
    .game_over_o      (over_o[1])
  );

  function automatic int nr_of(int i);
    return (i == 0) ? 5 : 9;
  endfunction

  function automatic int rc_of(int i);
    return (i == 0) ? 4 : 2;
  endfunction

  // ---------------- behavioural model ----------------
  localparam int PIdle   = 0;
  localparam int PGen    = 1;
  localparam int PArm    = 2;
  localparam int PWait   = 3;
  localparam int PLoad   = 4;
  localparam int PCheck  = 5;
  localparam int PResult = 6;
  localparam int PDone   = 7;

  int         ph [2];
  int         hold [2];
  logic       e_rng [2], e_load [2], e_reconf [2], e_ten [2], e_win [2], e_lose [2], e_over [2];
  logic [3:0] e_score [2], e_round [2];

  task automatic model_clear(int i);
    ph[i] = PIdle; hold[i] = 0;
    e_rng[i] = 0; e_load[i] = 0; e_reconf[i] = 0; e_ten[i] = 0;
    e_win[i] = 0; e_lose[i] = 0; e_over[i] = 0;
    e_score[i] = 0; e_round[i] = 0;
  endtask

  task automatic model_step(int i);
    int s;
    e_rng[i] = 0; e_load[i] = 0; e_reconf[i] = 0;
    if (!li[i]) begin
      model_clear(i);
    end else begin
      case (ph[i])
        PIdle, PDone: if (st[i]) begin
          ph[i] = PGen; e_rng[i] = 1; e_score[i] = 0; e_round[i] = 1; e_over[i] = 0;
        end
        PGen: begin ph[i] = PArm; e_reconf[i] = 1; end
        PArm: begin ph[i] = PWait; e_ten[i] = 1; end
        PWait: if (te[i]) begin
          ph[i] = PResult; e_ten[i] = 0; e_lose[i] = 1; hold[i] = rc_of(i);
        end else if (ans[i]) begin
          ph[i] = PLoad; e_ten[i] = 0; e_load[i] = 1;
        end
        PLoad: ph[i] = PCheck;
        PCheck: begin
          ph[i] = PResult; hold[i] = rc_of(i);
          if (sm[i]) begin
            e_win[i] = 1;
            s = int'(e_score[i]) + 1;
            e_score[i] = 4'((s > 9) ? 9 : s);
          end else begin
            e_lose[i] = 1;
          end
        end
        PResult: begin
          hold[i] = hold[i] - 1;
          if (hold[i] == 0) begin
            e_win[i] = 0; e_lose[i] = 0;
            if (int'(e_round[i]) == nr_of(i)) begin
              ph[i] = PDone; e_over[i] = 1;
            end else begin
              ph[i] = PGen; e_rng[i] = 1; e_round[i] = e_round[i] + 4'd1;
            end
          end
        end
        default: ph[i] = PIdle;
      endcase
    end
  endtask

  always @(posedge clk) begin
    if (rst_n) begin
      for (int i = 0; i < 2; i++) model_step(i);
    end
  end

  always @(negedge rst_n) begin
    for (int i = 0; i < 2; i++) model_clear(i);
  end

  function automatic logic [14:0] exp_vec(int i);
    return {e_rng[i], e_load[i], e_reconf[i], e_ten[i], e_score[i], e_round[i],
            e_win[i], e_lose[i], e_over[i]};
  endfunction

  function automatic logic [14:0] act_vec(int i);
    return {rng_o[i], load_o[i], reconf_o[i], ten_o[i], score_o[i], round_o[i],
            win_o[i], lose_o[i], over_o[i]};
  endfunction

  // Every-cycle comparison against the model.
  always @(negedge clk) begin
    for (int i = 0; i < 2; i++) begin
      n_checks++;
      if (act_vec(i) !== exp_vec(i)) begin
        n_errors++;
        $display("FAIL model_cmp dut%0d t=%0t actual=%h required=%h",
                 i, $time, act_vec(i), exp_vec(i));
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic chk(string name, int act, int req);
    n_checks++;
    if (act != req) begin
      n_errors++;
      $display("FAIL %s t=%0t actual=%0d required=%0d", name, $time, act, req);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start(int i);
    st[i] = 1; tick(); st[i] = 0;
  endtask

  // From GEN to WAIT; optionally fire stray start/answer pulses during GEN.
  task automatic to_wait(int i, bit stray);
    if (stray) begin ans[i] = 1; st[i] = 1; end
    tick();
    ans[i] = 0; st[i] = 0;
    tick();
  endtask

  // kind: 0 = answer, 1 = timeout, 2 = timeout and answer together.
  task automatic round_from_wait(int i, int dly, int kind, logic win);
    repeat (dly) tick();
    if (kind == 0) begin
      ans[i] = 1; sm[i] = win;
      tick();
      ans[i] = 0;
      chk("load_p1_after_answer", int'(load_o[i]), 1);
      tick(); tick();
      chk("win_led_two_after_load", int'(win_o[i]), int'(win));
      chk("lose_led_two_after_load", int'(lose_o[i]), int'(!win));
      sm[i] = 0;
    end else begin
      te[i] = 1; ans[i] = (kind == 2);
      tick();
      te[i] = 0; ans[i] = 0;
      chk("lose_led_on_timeout", int'(lose_o[i]), 1);
      chk("no_load_on_timeout", int'(load_o[i]), 0);
    end
    repeat (rc_of(i)) tick();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog t=%0t actual=running required=finished", $time);
    $fatal(1, "bench timeout");
  end

  initial begin
    rst_n = 0;
    for (int i = 0; i < 2; i++) begin
      li[i] = 0; st[i] = 0; ans[i] = 0; sm[i] = 0; te[i] = 0;
      model_clear(i);
    end
    repeat (2) @(posedge clk);
    #1;
    chk("reset_outputs_dut5", int'(act_vec(0)), 0);
    chk("reset_outputs_dut9", int'(act_vec(1)), 0);
    rst_n = 1;

    // Logged in but no start: must stay idle.
    li[0] = 1;
    repeat (3) tick();
    chk("idle_round_zero", int'(round_o[0]), 0);
    chk("idle_no_rng", int'(rng_o[0]), 0);

    // Start latency, then five winning rounds.
    pulse_start(0);
    chk("rng_gen_at_plus1", int'(rng_o[0]), 1);
    tick();
    chk("reconfig_at_plus2", int'(reconf_o[0]), 1);
    chk("rng_gen_single_cycle", int'(rng_o[0]), 0);
    tick();
    chk("timer_enable_at_plus3", int'(ten_o[0]), 1);
    round_from_wait(0, 0, 0, 1'b1);
    for (int r = 2; r <= 5; r++) begin
      to_wait(0, r == 3);
      round_from_wait(0, r - 1, 0, 1'b1);
    end
    chk("five_wins_score", int'(score_o[0]), 5);
    chk("five_wins_game_over", int'(over_o[0]), 1);
    chk("five_wins_round", int'(round_o[0]), 5);
    ans[0] = 1; tick(); ans[0] = 0; tick();
    chk("done_score_frozen", int'(score_o[0]), 5);

    // Restart, win, simultaneous timeout+answer, then logout in round 3 WAIT.
    pulse_start(0);
    chk("restart_score_clear", int'(score_o[0]), 0);
    chk("restart_round_one", int'(round_o[0]), 1);
    chk("restart_game_over_clear", int'(over_o[0]), 0);
    to_wait(0, 0);
    round_from_wait(0, 1, 0, 1'b1);
    chk("round1_win_score", int'(score_o[0]), 1);
    to_wait(0, 0);
    round_from_wait(0, 0, 2, 1'b1);
    chk("tie_score_unchanged", int'(score_o[0]), 1);
    chk("tie_next_round", int'(round_o[0]), 3);
    to_wait(0, 0);
    tick();
    li[0] = 0;
    tick();
    chk("logout_score_zero", int'(score_o[0]), 0);
    chk("logout_timer_off", int'(ten_o[0]), 0);
    chk("logout_round_zero", int'(round_o[0]), 0);
    tick();
    li[0] = 1;
    repeat (3) tick();
    chk("relogin_stays_idle", int'(round_o[0]), 0);
    li[0] = 0;
    tick();

    // Nine-round game, all wins, then restart from DONE.
    li[1] = 1;
    pulse_start(1);
    to_wait(1, 0);
    for (int r = 0; r < 9; r++) begin
      round_from_wait(1, r % 3, 0, 1'b1);
      if (r < 8) to_wait(1, 0);
    end
    chk("nine_wins_score", int'(score_o[1]), 9);
    chk("nine_wins_game_over", int'(over_o[1]), 1);
    chk("nine_wins_round", int'(round_o[1]), 9);
    pulse_start(1);
    chk("restart9_score_clear", int'(score_o[1]), 0);
    chk("restart9_round_one", int'(round_o[1]), 1);
    chk("restart9_rng", int'(rng_o[1]), 1);

    // Plain timeout, then asynchronous reset in the middle of CHECK.
    to_wait(1, 0);
    round_from_wait(1, 2, 1, 1'b0);
    chk("timeout_score_zero", int'(score_o[1]), 0);
    to_wait(1, 0);
    ans[1] = 1; sm[1] = 1;
    tick();
    ans[1] = 0;
    tick();
    #1 rst_n = 0;
    #1;
    chk("async_reset_dut9_zero", int'(act_vec(1)), 0);
    chk("async_reset_dut5_zero", int'(act_vec(0)), 0);
    sm[1] = 0;
    #1 rst_n = 1;
    repeat (3) tick();
    chk("post_reset_needs_start", int'(round_o[1]), 0);
    chk("post_reset_no_rng", int'(rng_o[1]), 0);
    pulse_start(1);
    chk("post_reset_start_rng", int'(rng_o[1]), 1);

    li[0] = 0; li[1] = 0;
    repeat (2) tick();
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
